noc_merge_arb: RTL and testbench
================================

# noc_merge_arb

Two-input round-robin merge arbiter for the NoC router output stage. Combines two 9-bit packet streams (e.g. the Out0 ports of two address-decoder instances headed to the same link) into one output channel. Holds a one-entry output register with full throughput, and tags every forwarded packet with the index of the input it came from.

## Interface

Parameters:
- W, 9, packet width; the address field is bits [8:5].

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- _RESET  input  1  reset; synchronous, active-low.
- in0_data  input  W  packet from requester 0.
- in0_valid  input  1  requester 0 offers a packet.
- in0_ready  output  1  requester 0 packet accepted this cycle.
- in1_data  input  W  packet from requester 1.
- in1_valid  input  1  requester 1 offers a packet.
- in1_ready  output  1  requester 1 packet accepted this cycle.
- out_data  output  W  forwarded packet.
- out_src  output  1  source index of out_data (0 or 1).
- out_valid  output  1  output register full.
- out_ready  input  1  downstream accepts out_data this cycle.
- grant_cnt0  output  16  packets granted to input 0 (only with MERGE_GRANT_CNT_EN).
- grant_cnt1  output  16  packets granted to input 1 (only with MERGE_GRANT_CNT_EN).

## Operation

- Transfer on any channel occurs when valid && ready on the same rising edge.
- Output register states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- Register write enable: free = !out_valid || out_ready.
- Grant, combinational:
  - Only in0_valid: grant 0.
  - Only in1_valid: grant 1.
  - Both valid: grant !last_grant.
  - Neither valid: no grant.
- inN_ready = free && (grant == N) && inN_valid.
  - Never both high in the same cycle.
  - The ready of a non-granted input is 0.
- On an accepted input:
  - out_data <= inN_data, out_src <= N, out_valid <= 1.
  - last_grant <= N.
- On out_ready with no accepted input: out_valid <= 0. out_data and out_src hold their values.
- Drain and refill in the same cycle (FULL, out_ready=1, an input accepted): the register is overwritten and out_valid stays 1. No bubble.
- last_grant updates only on an accepted transfer, never on an offer that is not taken.
- out_data and out_src are stable while out_valid=1 && out_ready=0.
- Inputs must hold data while valid && !ready.
  - The arbiter does not rely on this for correctness.
  - The bench asserts it.

## Timing

- Latency: input accept to out_valid is 1 cycle.
- Throughput: 1 packet/cycle sustained when out_ready=1.
- Fairness: under continuous requests on both inputs, grants strictly alternate. Worst-case wait for an input is 1 packet of the other input.
- Reset, when _RESET=0 at a rising edge:
  - out_valid=0, out_data=0, out_src=0.
  - last_grant=1, so input 0 wins the first contention.
  - grant counters = 0.
- During reset, in0_ready=0 and in1_ready=0 (combinationally gated by !_RESET).
- Reset mid-operation: a held packet is discarded and no transfer completes in that cycle.
- First cycle after reset release: both readies may assert per the grant rules.

## Configuration

- Macro: MERGE_GRANT_CNT_EN.
- Defined:
  - Two 16-bit grant counters increment on each accepted input of their index.
  - Counters saturate at 16'hFFFF with no wrap.
  - Counters are cleared by reset and driven on grant_cnt0 and grant_cnt1.
- Undefined:
  - The counters are not instantiated.
  - grant_cnt0 and grant_cnt1 ports are absent.
  - All other behaviour is identical.

## Structure

- Shared package noc_pkg holds:
  - PKT_W = 9.
  - ADDR_HI = 8, ADDR_LO = 5.
  - The typedef pkt_t (logic [PKT_W-1:0]).
  - The typedef src_t (1 bit).
- Sub-module rr_arb2:
  - Inputs: req[1:0], last_grant.
  - Outputs: gnt[1:0] (one-hot or zero).
  - Purely combinational.
- The top module holds the output register, last_grant and the optional counters.

## Test plan

- Single-input stream: in0 sends 9'h1A0, 9'h0E1, out_ready=1 → out_data 9'h1A0 then 9'h0E1 on consecutive cycles, out_src=0, in1_ready stays 0.
- Contention after reset: both valid, in0=9'h100, in1=9'h020 → in0 accepted first (out_src=0), then in1 (out_src=1), then alternation 0,1,0,1 for 8 packets.
- Backpressure: output FULL with 9'h155 and out_ready=0 for 5 cycles → out_data held at 9'h155, both readies 0. out_ready=1 → next packet accepted the same cycle with no bubble.
- Reset mid-operation: out_valid=1 holding 9'h0FF, _RESET=0 for one edge → out_valid=0, out_data=0, last_grant=1. The next contention grants input 0.
- Counter saturation (MERGE_GRANT_CNT_EN): force grant_cnt0 to 16'hFFFE, grant 3 packets to input 0 → counter reads 16'hFFFF and holds. grant_cnt1 is unchanged.
- Idle: no valid for 10 cycles after one drained packet → out_valid=0 throughout, last_grant unchanged.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC definitions: packet/source types, address field bounds and the
// output-register state encoding used by the merge arbiter.
package noc_pkg;

    localparam int PKT_W   = 9;
    localparam int ADDR_HI = 8;
    localparam int ADDR_LO = 5;

    typedef logic [PKT_W-1:0] pkt_t;
    typedef logic             src_t;

    typedef enum logic {
        OBUF_EMPTY = 1'b0,
        OBUF_FULL  = 1'b1
    } obuf_state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant logic, purely combinational.
// Grant is one-hot, or zero when nobody requests.
module rr_arb2
    import noc_pkg::*;
(
    input  logic [1:0] req,
    input  src_t       last_grant,
    output logic [1:0] gnt
);

    // On contention the requester that did not win last time goes first.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/noc_merge_arb.sv
// Two-input round-robin merge into a one-entry full-throughput output register.
// Optional per-input grant counters are built when MERGE_GRANT_CNT_EN is defined.
module noc_merge_arb
    import noc_pkg::*;
#(
    parameter int W = PKT_W
)
(
    input  logic         CLK,
    input  logic         _RESET,
    input  logic [W-1:0] in0_data,
    input  logic         in0_valid,
    output logic         in0_ready,
    input  logic [W-1:0] in1_data,
    input  logic         in1_valid,
    output logic         in1_ready,
    output logic [W-1:0] out_data,
    output logic         out_src,
    output logic         out_valid,
    input  logic         out_ready
`ifdef MERGE_GRANT_CNT_EN
    ,
    output logic [15:0]  grant_cnt0,
    output logic [15:0]  grant_cnt1
`endif
);

    obuf_state_e state, state_next;
    logic [1:0]  req;
    logic [1:0]  gnt;
    logic        free;
    logic        accept;
    src_t        sel;
    src_t        last_grant;

    assign req = {in1_valid, in0_valid};

    rr_arb2 u_arb (
        .req        (req),
        .last_grant (last_grant),
        .gnt        (gnt)
    );

    // Readies are masked by reset so nothing is taken while the block is held.
    assign free      = (state == OBUF_EMPTY) || out_ready;
    assign in0_ready = _RESET && free && gnt[0];
    assign in1_ready = _RESET && free && gnt[1];
    assign accept    = in0_ready || in1_ready;
    assign sel       = in1_ready;
    assign out_valid = (state == OBUF_FULL);

    always_comb begin
        state_next = state;
        case (state)
            OBUF_EMPTY: if (accept) state_next = OBUF_FULL;
            OBUF_FULL:  if (!accept && out_ready) state_next = OBUF_EMPTY;
            default:    state_next = OBUF_EMPTY;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!_RESET) state <= OBUF_EMPTY;
        else         state <= state_next;
    end

    // A drain with no refill leaves data/src untouched; last_grant starts at 1
    // so input 0 wins the first contention.
    always_ff @(posedge CLK) begin
        if (!_RESET) begin
            out_data   <= '0;
            out_src    <= 1'b0;
            last_grant <= 1'b1;
        end else if (accept) begin
            out_data   <= sel ? in1_data : in0_data;
            out_src    <= sel;
            last_grant <= sel;
        end
    end

`ifdef MERGE_GRANT_CNT_EN
    logic [15:0] cnt0_q;
    logic [15:0] cnt1_q;

    always_ff @(posedge CLK) begin
        if (!_RESET) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (in0_ready && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
            if (in1_ready && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_noc_merge_arb.sv
// Self-checking bench for noc_merge_arb: reference model plus scoreboard queue,
// a contention vector table and hand-written multi-cycle sequences.
module tb_noc_merge_arb;
    import noc_pkg::*;

    logic CLK;
    logic _RESET;
    pkt_t in0_data, in1_data, out_data;
    logic in0_valid, in0_ready, in1_valid, in1_ready;
    logic out_src, out_valid, out_ready;
`ifdef MERGE_GRANT_CNT_EN
    logic [15:0] grant_cnt0, grant_cnt1;
    logic [15:0] m_cnt0, m_cnt1;
`endif

    noc_merge_arb dut (
        .CLK        (CLK),
        ._RESET     (_RESET),
        .in0_data   (in0_data),
        .in0_valid  (in0_valid),
        .in0_ready  (in0_ready),
        .in1_data   (in1_data),
        .in1_valid  (in1_valid),
        .in1_ready  (in1_ready),
        .out_data   (out_data),
        .out_src    (out_src),
        .out_valid  (out_valid),
        .out_ready  (out_ready)
`ifdef MERGE_GRANT_CNT_EN
        ,
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Requesters must hold an offered packet until it is taken.
    assert property (@(posedge CLK) disable iff (!_RESET)
        (in0_valid && !in0_ready) |=> (in0_valid && $stable(in0_data)));
    assert property (@(posedge CLK) disable iff (!_RESET)
        (in1_valid && !in1_ready) |=> (in1_valid && $stable(in1_data)));

    typedef struct {
        pkt_t data;
        logic src;
    } exp_t;

    typedef struct {
        logic v0;
        pkt_t d0;
        logic v1;
        pkt_t d1;
        logic ordy;
        logic er0;
        logic er1;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;
    logic m_valid;
    logic m_last;
    logic got_r0, got_r1;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check readies/output against the model,
    // then advance the model across the rising edge.
    task automatic applyStimulus(input logic v0, input pkt_t d0, input logic v1, input pkt_t d1,
                                 input logic ordy, output logic r0, output logic r1);
        logic mfree, er0, er1;
        exp_t e;
        in0_valid = v0;
        in0_data  = d0;
        in1_valid = v1;
        in1_data  = d1;
        out_ready = ordy;
        #1;
        mfree = !m_valid || ordy;
        er0 = mfree && v0 && (!v1 || m_last);
        er1 = mfree && v1 && (!v0 || !m_last);
        r0 = in0_ready;
        r1 = in1_ready;
        checkOutput("in0_ready", {15'd0, in0_ready}, {15'd0, er0});
        checkOutput("in1_ready", {15'd0, in1_ready}, {15'd0, er1});
        checkOutput("out_valid", {15'd0, out_valid}, {15'd0, m_valid});
`ifdef MERGE_GRANT_CNT_EN
        checkOutput("grant_cnt0", grant_cnt0, m_cnt0);
        checkOutput("grant_cnt1", grant_cnt1, m_cnt1);
        if (er0 && m_cnt0 != 16'hFFFF) m_cnt0 = m_cnt0 + 16'd1;
        if (er1 && m_cnt1 != 16'hFFFF) m_cnt1 = m_cnt1 + 16'd1;
`endif
        if (m_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL scoreboard: got empty queue expected entry");
            end else begin
                checkOutput("out_data", {7'd0, out_data}, {7'd0, sb[0].data});
                checkOutput("out_src", {15'd0, out_src}, {15'd0, sb[0].src});
                if (ordy) void'(sb.pop_front());
            end
        end
        if (er0) begin
            e.data = d0; e.src = 1'b0; sb.push_back(e); m_last = 1'b0;
        end else if (er1) begin
            e.data = d1; e.src = 1'b1; sb.push_back(e); m_last = 1'b1;
        end
        m_valid = er0 || er1 || (m_valid && !ordy);
        @(posedge CLK);
        #1;
    endtask

    task automatic applyReset(input logic v0, input logic v1);
        _RESET    = 1'b0;
        in0_valid = v0;
        in0_data  = 9'h100;
        in1_valid = v1;
        in1_data  = 9'h020;
        out_ready = 1'b1;
        #1;
        checkOutput("rst_in0_ready", {15'd0, in0_ready}, 16'd0);
        checkOutput("rst_in1_ready", {15'd0, in1_ready}, 16'd0);
        @(posedge CLK);
        #1;
        checkOutput("rst_out_valid", {15'd0, out_valid}, 16'd0);
        checkOutput("rst_out_data", {7'd0, out_data}, 16'd0);
        checkOutput("rst_out_src", {15'd0, out_src}, 16'd0);
        sb.delete();
        m_valid = 1'b0;
        m_last  = 1'b1;
`ifdef MERGE_GRANT_CNT_EN
        m_cnt0 = 16'd0;
        m_cnt1 = 16'd0;
`endif
        _RESET = 1'b1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic r0, r1;
        // Contention after reset: strict alternation starting with input 0.
        for (int i = 0; i < 8; i++)
            vecs[i] = '{1'b1, 9'h100, 1'b1, 9'h020, 1'b1, (i % 2) == 0, (i % 2) == 1};
        vecs[8] = '{1'b1, 9'h100, 1'b0, 9'h000, 1'b1, 1'b1, 1'b0};
        vecs[9] = '{1'b0, 9'h000, 1'b0, 9'h000, 1'b1, 1'b0, 1'b0};

        _RESET = 1'b0; in0_valid = 1'b0; in1_valid = 1'b0;
        in0_data = '0; in1_data = '0; out_ready = 1'b0;
        m_valid = 1'b0; m_last = 1'b1;
`ifdef MERGE_GRANT_CNT_EN
        m_cnt0 = 16'd0; m_cnt1 = 16'd0;
`endif

        $display("[TB] reset with both requesters valid");
        applyReset(1'b1, 1'b1);

        $display("[TB] single-input stream");
        applyStimulus(1'b1, 9'h1A0, 1'b0, 9'h000, 1'b1, r0, r1);
        applyStimulus(1'b1, 9'h0E1, 1'b0, 9'h000, 1'b1, r0, r1);
        applyStimulus(1'b0, 9'h000, 1'b0, 9'h000, 1'b1, r0, r1);

        $display("[TB] contention table");
        applyReset(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(vecs[i].v0, vecs[i].d0, vecs[i].v1, vecs[i].d1, vecs[i].ordy, r0, r1);
            checkOutput($sformatf("vec%0d_in0_ready", i), {15'd0, r0}, {15'd0, vecs[i].er0});
            checkOutput($sformatf("vec%0d_in1_ready", i), {15'd0, r1}, {15'd0, vecs[i].er1});
        end

        $display("[TB] backpressure then drain-and-refill");
        applyStimulus(1'b1, 9'h155, 1'b0, 9'h000, 1'b1, r0, r1);
        for (int i = 0; i < 5; i++)
            applyStimulus(1'b1, 9'h0AA, 1'b1, 9'h033, 1'b0, r0, r1);
        applyStimulus(1'b1, 9'h0AA, 1'b1, 9'h033, 1'b1, r0, r1);
        checkOutput("refill_in1_ready", {15'd0, r1}, 16'd1);
        applyStimulus(1'b1, 9'h0AA, 1'b0, 9'h000, 1'b1, r0, r1);
        applyStimulus(1'b0, 9'h000, 1'b0, 9'h000, 1'b1, r0, r1);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 9'h0FF, 1'b0, 9'h000, 1'b0, r0, r1);
        applyStimulus(1'b0, 9'h000, 1'b0, 9'h000, 1'b0, r0, r1);
        applyReset(1'b1, 1'b1);
        applyStimulus(1'b1, 9'h100, 1'b1, 9'h020, 1'b1, r0, r1);
        checkOutput("post_reset_grant0", {15'd0, r0}, 16'd1);
        applyStimulus(1'b1, 9'h100, 1'b1, 9'h020, 1'b1, r0, r1);
        applyStimulus(1'b1, 9'h100, 1'b0, 9'h000, 1'b1, r0, r1);

        $display("[TB] idle for 10 cycles");
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 9'h000, 1'b0, 9'h000, 1'b1, r0, r1);
        applyStimulus(1'b1, 9'h101, 1'b1, 9'h021, 1'b1, r0, r1);
        checkOutput("post_idle_grant1", {15'd0, r1}, 16'd1);
        applyStimulus(1'b1, 9'h101, 1'b0, 9'h000, 1'b1, r0, r1);
        applyStimulus(1'b0, 9'h000, 1'b0, 9'h000, 1'b1, r0, r1);

`ifdef MERGE_GRANT_CNT_EN
        $display("[TB] grant counter saturation");
        force dut.cnt0_q = 16'hFFFE;
        #1;
        release dut.cnt0_q;
        m_cnt0 = 16'hFFFE;
        for (int i = 0; i < 3; i++)
            applyStimulus(1'b1, 9'h040 + 9'(i), 1'b0, 9'h000, 1'b1, r0, r1);
        applyStimulus(1'b0, 9'h000, 1'b0, 9'h000, 1'b1, r0, r1);
        checkOutput("cnt0_saturated", grant_cnt0, 16'hFFFF);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
